pipe_in_fifo64: RTL and testbench

- Responder end of the 64-bit pipe-in read interface (read / data / valid / empty) consumed by the block DES stepping machine.
- Accepts 16-bit host-side words, packs four into one 64-bit block, buffers blocks in a synchronous FIFO, and serves them to the consumer with 1-cycle read latency.
- Sits between the host pipe endpoint data strobe and the DES control state machine, in the DES clock domain.

---
 rtl/pipe_in_fifo64.sv | 126 ++++++++++++
 tb/tb_pipe_in_fifo64.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_in_fifo64.sv
// pipe_in_fifo64: packs 16-bit host words into 64-bit blocks, buffers them
// in a synchronous FIFO and serves one block per accepted read with a
// 1-cycle registered read latency.
// Optional build macro PIPE_IN_FIFO64_UNDERFLOW_EN adds a sticky underflow flag.
module pipe_in_fifo64 #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_reset,
    input  logic              wr_en,
    input  logic [15:0]       wr_data,
    input  logic              read,
    output logic [63:0]       data,
    output logic              valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef PIPE_IN_FIFO64_UNDERFLOW_EN
    ,
    output logic              underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        phase_p0;
    logic [47:0]       blk_p0;
    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              commit;
    logic              rd_acc;
    logic              wr_ok;

    // Commit/read decisions; a flush overrides both. When full, a same-cycle
    // accepted read frees the head slot so the commit still lands.
    always_comb begin
        commit    = wr_en && (phase_p0 == 2'd3) && !fifo_reset;
        rd_acc    = read && (count != '0) && !fifo_reset;
        wr_ok     = commit && ((count != FULL_CNT) || rd_acc);
        count_nxt = count;
        if (wr_ok && !rd_acc)
            count_nxt = count + (ADDR_W + 1)'(1);
        else if (rd_acc && !wr_ok)
            count_nxt = count - (ADDR_W + 1)'(1);
    end

    // Staging lanes for words 0..2; word 3 goes straight into the commit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (phase_p0)
                2'd0:    blk_p0[15:0]  <= wr_data;
                2'd1:    blk_p0[31:16] <= wr_data;
                2'd2:    blk_p0[47:32] <= wr_data;
                default: ;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= {wr_data, blk_p0};
    end

    // Pointers, count, phase and registered flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_p0 <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            valid    <= 1'b0;
            overflow <= 1'b0;
`ifdef PIPE_IN_FIFO64_UNDERFLOW_EN
            underflow <= 1'b0;
`endif
        end else if (fifo_reset) begin
            phase_p0 <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            valid    <= 1'b0;
            overflow <= 1'b0;
`ifdef PIPE_IN_FIFO64_UNDERFLOW_EN
            underflow <= 1'b0;
`endif
        end else begin
            if (wr_en)
                phase_p0 <= phase_p0 + 2'd1;
            if (wr_ok)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_CNT);
            valid <= rd_acc;
            if (commit && !wr_ok)
                overflow <= 1'b1;
`ifdef PIPE_IN_FIFO64_UNDERFLOW_EN
            if (read && (count == '0))
                underflow <= 1'b1;
`endif
        end
    end

    // Registered read port; data holds between accepted reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data <= '0;
        else if (fifo_reset)
            data <= '0;
        else if (rd_acc)
            data <= mem[rd_ptr];
    end

endmodule

// File: tb/tb_pipe_in_fifo64.sv
// Directed self-checking bench for pipe_in_fifo64 (ADDR_W=4).
module tb_pipe_in_fifo64;

    logic        clk;
    logic        reset;
    logic        fifo_reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        read;
    logic [63:0] data;
    logic        valid;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
`ifdef PIPE_IN_FIFO64_UNDERFLOW_EN
    logic        underflow;
`endif

    int total = 0;
    int bad   = 0;

    pipe_in_fifo64 #(.ADDR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_reset (fifo_reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .read       (read),
        .data       (data),
        .valid      (valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow)
`ifdef PIPE_IN_FIFO64_UNDERFLOW_EN
        ,
        .underflow  (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [15:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    function automatic logic [15:0] wd(input int b, input int k);
        return {8'(b), 8'(k)};
    endfunction

    function automatic logic [63:0] blk(input int b);
        return {wd(b, 3), wd(b, 2), wd(b, 1), wd(b, 0)};
    endfunction

    task automatic wr_blk(input int b);
        for (int k = 0; k < 4; k++) wr_word(wd(b, k));
    endtask

    task automatic rd_one(input string tag, input logic [63:0] exp);
        read = 1'b1;
        tick();
        read = 1'b0;
        chk({tag, "_valid"}, 64'(valid), 64'd1);
        chk({tag, "_data"}, data, exp);
    endtask

    task automatic flush();
        fifo_reset = 1'b1;
        tick();
        fifo_reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        fifo_reset = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        read       = 1'b0;
        tick();
        tick();
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        reset = 1'b0;
        tick();

        // Pack order
        wr_word(16'h1111);
        wr_word(16'h2222);
        wr_word(16'h3333);
        chk("pack_partial_cnt", 64'(count), 64'd0);
        wr_word(16'h4444);
        chk("pack_cnt", 64'(count), 64'd1);
        chk("pack_empty", 64'(empty), 64'd0);
        rd_one("pack", 64'h4444_3333_2222_1111);
        chk("pack_empty_after", 64'(empty), 64'd1);
        chk("pack_cnt_after", 64'(count), 64'd0);
        tick();
        chk("pack_valid_pulse", 64'(valid), 64'd0);
        chk("pack_data_hold", data, 64'h4444_3333_2222_1111);

        // Partial block invisible
        wr_word(16'hA001);
        wr_word(16'hA002);
        wr_word(16'hA003);
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("part_valid", 64'(valid), 64'd0);
        chk("part_empty", 64'(empty), 64'd1);
        wr_word(16'hA004);
        chk("part_cnt", 64'(count), 64'd1);
        chk("part_empty2", 64'(empty), 64'd0);
        rd_one("part", 64'hA004_A003_A002_A001);

        // Fill and overflow
        flush();
        for (int b = 0; b < 16; b++) wr_blk(b);
        chk("fill_cnt", 64'(count), 64'd16);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_ovf", 64'(overflow), 64'd0);
        wr_blk(16);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_cnt", 64'(count), 64'd16);
        for (int b = 0; b < 16; b++) rd_one($sformatf("ovf_rd%0d", b), blk(b));
        chk("ovf_empty", 64'(empty), 64'd1);
        chk("ovf_full", 64'(full), 64'd0);

        // Back-to-back drain
        flush();
        for (int b = 0; b < 3; b++) wr_blk(30 + b);
        read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 3) begin
                chk($sformatf("b2b_valid%0d", i), 64'(valid), 64'd1);
                chk($sformatf("b2b_data%0d", i), data, blk(30 + i));
            end else begin
                chk($sformatf("b2b_valid%0d", i), 64'(valid), 64'd0);
            end
        end
        read = 1'b0;
        chk("b2b_empty", 64'(empty), 64'd1);

        // Simultaneous commit and read at full
        flush();
        for (int b = 0; b < 16; b++) wr_blk(b);
        for (int k = 0; k < 3; k++) wr_word(wd(50, k));
        wr_en   = 1'b1;
        wr_data = wd(50, 3);
        read    = 1'b1;
        tick();
        wr_en = 1'b0;
        read  = 1'b0;
        chk("sim_valid", 64'(valid), 64'd1);
        chk("sim_data", data, blk(0));
        chk("sim_cnt", 64'(count), 64'd16);
        chk("sim_full", 64'(full), 64'd1);
        chk("sim_ovf", 64'(overflow), 64'd0);
        for (int b = 1; b < 16; b++) rd_one($sformatf("sim_rd%0d", b), blk(b));
        rd_one("sim_last", blk(50));
        chk("sim_empty", 64'(empty), 64'd1);

        // Flush mid-block, flush overrides a same-cycle write
        wr_word(16'hBEEF);
        wr_word(16'hCAFE);
        fifo_reset = 1'b1;
        wr_en      = 1'b1;
        wr_data    = 16'hDEAD;
        tick();
        fifo_reset = 1'b0;
        wr_en      = 1'b0;
        chk("flush_cnt", 64'(count), 64'd0);
        chk("flush_data", data, 64'd0);
        wr_word(16'h000A);
        wr_word(16'h000B);
        wr_word(16'h000C);
        wr_word(16'h000D);
        rd_one("flush", 64'h000D_000C_000B_000A);

        // Async reset mid-read
        wr_blk(60);
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("arst_pre_valid", 64'(valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(valid), 64'd0);
        chk("arst_data", data, 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        tick();
        reset = 1'b0;
        tick();

`ifdef PIPE_IN_FIFO64_UNDERFLOW_EN
        chk("udf_init", 64'(underflow), 64'd0);
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("udf_set", 64'(underflow), 64'd1);
        chk("udf_valid", 64'(valid), 64'd0);
        tick();
        tick();
        chk("udf_sticky", 64'(underflow), 64'd1);
        flush();
        chk("udf_clear", 64'(underflow), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
